// File: rtl/pc_source_controller_if.sv
// Fetch-side bundle between the PC-select controller and the pipeline datapath.
// The controller takes the slave view; the datapath, which supplies the mux output, takes the master view.
interface pc_source_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  mult_busy;
  logic                  hazard_stall;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus_step;
  logic [ADDR_WIDTH-1:0] mux_target;
  logic                  pc_source;
  logic                  pc_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  misalign;
  logic [15:0]           redirect_count;

  modport master (
    output branch_taken, branch_target, mult_busy, hazard_stall, next_pc,
    input  pc, pc_plus_step, mux_target, pc_source, pc_write,
           if_id_flush, id_ex_flush, misalign, redirect_count
  );

  modport slave (
    input  branch_taken, branch_target, mult_busy, hazard_stall, next_pc,
    output pc, pc_plus_step, mux_target, pc_source, pc_write,
           if_id_flush, id_ex_flush, misalign, redirect_count
  );
endinterface

// File: rtl/pc_source_controller.sv
// PC register plus mux-select sequencer that holds a taken branch across multiplier/load-use stalls.
// Latency: unstalled redirect lands on pc at the next edge; a stalled redirect fires in the first unstalled cycle.
module pc_source_controller #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    PC_STEP      = 4
) (
  input logic                   clk,
  input logic                   reset,
  pc_source_controller_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  typedef enum logic {RUN, PENDING} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pend_target;
  logic                  pend_misalign;
  logic                  misalign;
  logic [15:0]           redirect_count;

  logic                  stall;
  logic                  fire;
  logic                  fire_misalign;
  logic                  latch_pend;
  logic                  pc_source;
  logic                  flush;
  logic                  pc_write;
  logic [ADDR_WIDTH-1:0] mux_target;
  logic [ADDR_WIDTH-1:0] aligned_target;
  logic                  target_misaligned;

  assign stall             = bus.mult_busy | bus.hazard_stall;
  assign aligned_target    = {bus.branch_target[ADDR_WIDTH-1:2], 2'b00};
  assign target_misaligned = |bus.branch_target[1:0];

  always_comb begin
    state_nxt     = state;
    mux_target    = aligned_target;
    pc_source     = 1'b0;
    flush         = 1'b0;
    fire          = 1'b0;
    fire_misalign = 1'b0;
    latch_pend    = 1'b0;
    pc_write      = ~stall;

    case (state)
      RUN: begin
        if (bus.branch_taken && !stall) begin
          pc_source     = 1'b1;
          flush         = 1'b1;
          fire          = 1'b1;
          fire_misalign = target_misaligned;
        end else if (bus.branch_taken && stall) begin
          latch_pend = 1'b1;
          state_nxt  = PENDING;
        end
      end
      PENDING: begin
        // The older, stalled branch owns the redirect; anything arriving now is wrong-path.
        mux_target = pend_target;
        if (!stall) begin
          pc_source     = 1'b1;
          flush         = 1'b1;
          fire          = 1'b1;
          fire_misalign = pend_misalign;
          state_nxt     = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase

    if (reset) begin
      pc_source  = 1'b0;
      flush      = 1'b0;
      pc_write   = 1'b0;
      fire       = 1'b0;
      latch_pend = 1'b0;
      state_nxt  = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pend_target    <= '0;
      pend_misalign  <= 1'b0;
      misalign       <= 1'b0;
      redirect_count <= '0;
    end else begin
      state <= state_nxt;
      if (pc_write) pc <= bus.next_pc;
      if (latch_pend) begin
        pend_target   <= aligned_target;
        pend_misalign <= target_misaligned;
      end
      if (fire) begin
        if (fire_misalign) misalign <= 1'b1;
        if (redirect_count != 16'hFFFF) redirect_count <= redirect_count + 16'd1;
      end
    end
  end

  assign bus.pc             = pc;
  assign bus.pc_plus_step   = pc + STEP;
  assign bus.mux_target     = mux_target;
  assign bus.pc_source      = pc_source;
  assign bus.pc_write       = pc_write;
  assign bus.if_id_flush    = flush;
  assign bus.id_ex_flush    = flush;
  assign bus.misalign       = misalign;
  assign bus.redirect_count = redirect_count;

endmodule

// File: tb/tb_pc_source_controller.sv
// Directed-vector bench for pc_source_controller; the bench closes the PC mux loop itself.
module tb_pc_source_controller;
  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  pc_source_controller_if #(.ADDR_WIDTH(32)) bus ();

  pc_source_controller #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0000),
    .PC_STEP     (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // External PC-select multiplexer.
  assign bus.next_pc = bus.pc_source ? bus.mux_target : bus.pc_plus_step;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_comb(input string tag, input logic src, input logic fl, input logic wr);
    check({tag, "_src"}, {31'd0, bus.pc_source}, {31'd0, src});
    check({tag, "_ifid"}, {31'd0, bus.if_id_flush}, {31'd0, fl});
    check({tag, "_idex"}, {31'd0, bus.id_ex_flush}, {31'd0, fl});
    check({tag, "_wr"}, {31'd0, bus.pc_write}, {31'd0, wr});
  endtask

  initial begin
    reset             = 1'b1;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.mult_busy     = 1'b0;
    bus.hazard_stall  = 1'b0;
    tick();
    tick();

    // Reset masks a branch request on the combinational outputs.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    settle();
    check_comb("rst", 1'b0, 1'b0, 1'b0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_cnt", {16'd0, bus.redirect_count}, 32'd0);
    check("rst_mis", {31'd0, bus.misalign}, 32'd0);
    bus.branch_taken = 1'b0;
    reset            = 1'b0;

    // Free run.
    settle();
    check("run_pc0", bus.pc, 32'h0);
    check("run_step", bus.pc_plus_step, 32'h4);
    check_comb("run0", 1'b0, 1'b0, 1'b1);
    tick(); check("run_pc4", bus.pc, 32'h4);
    tick(); check("run_pc8", bus.pc, 32'h8);
    tick(); check("run_pc12", bus.pc, 32'hC);
    check_comb("run3", 1'b0, 1'b0, 1'b1);

    // Unstalled branch.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    settle();
    check_comb("br", 1'b1, 1'b1, 1'b1);
    check("br_tgt", bus.mux_target, 32'h100);
    tick();
    bus.branch_taken = 1'b0;
    check("br_pc", bus.pc, 32'h100);
    check("br_cnt", {16'd0, bus.redirect_count}, 32'd1);

    // Branch arriving during a 5-cycle multiplier stall, plus a younger wrong-path branch.
    for (int c = 1; c <= 5; c++) begin
      bus.mult_busy     = 1'b1;
      bus.branch_taken  = (c == 1 || c == 3);
      bus.branch_target = (c == 3) ? 32'h300 : 32'h200;
      settle();
      check_comb($sformatf("stl%0d", c), 1'b0, 1'b0, 1'b0);
      tick();
      check($sformatf("stl%0d_pc", c), bus.pc, 32'h100);
    end
    bus.mult_busy     = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h300;
    settle();
    check_comb("pend_fire", 1'b1, 1'b1, 1'b1);
    check("pend_tgt", bus.mux_target, 32'h200);
    tick();
    bus.branch_taken = 1'b0;
    check("pend_pc", bus.pc, 32'h200);
    check("pend_cnt", {16'd0, bus.redirect_count}, 32'd2);
    settle();
    check_comb("pend_after", 1'b0, 1'b0, 1'b1);
    tick();
    check("pend_pc2", bus.pc, 32'h204);

    // Misaligned target.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h103;
    settle();
    check("mis_tgt", bus.mux_target, 32'h100);
    tick();
    bus.branch_taken = 1'b0;
    check("mis_pc", bus.pc, 32'h100);
    check("mis_flag", {31'd0, bus.misalign}, 32'd1);
    check("mis_cnt", {16'd0, bus.redirect_count}, 32'd3);
    tick();
    tick();
    check("mis_sticky", {31'd0, bus.misalign}, 32'd1);
    check("mis_pc2", bus.pc, 32'h108);

    // Reset while a redirect is pending.
    bus.hazard_stall  = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h400;
    tick();
    bus.branch_taken = 1'b0;
    check("rp_hold", bus.pc, 32'h108);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rp_pc", bus.pc, 32'h0);
    check("rp_mis", {31'd0, bus.misalign}, 32'd0);
    check("rp_cnt", {16'd0, bus.redirect_count}, 32'd0);
    settle();
    check_comb("rp_stall", 1'b0, 1'b0, 1'b0);
    tick();
    bus.hazard_stall = 1'b0;
    check("rp_pc_held", bus.pc, 32'h0);
    settle();
    check_comb("rp_clear", 1'b0, 1'b0, 1'b1);
    tick();
    check("rp_pc4", bus.pc, 32'h4);
    check("rp_cnt2", {16'd0, bus.redirect_count}, 32'd0);

    // Counter saturation: a redirect every cycle.
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    for (int i = 0; i < 65534; i++) tick();
    check("sat_fffe", {16'd0, bus.redirect_count}, 32'h0000_FFFE);
    tick();
    check("sat_ffff", {16'd0, bus.redirect_count}, 32'h0000_FFFF);
    tick();
    tick();
    tick();
    check("sat_hold", {16'd0, bus.redirect_count}, 32'h0000_FFFF);
    check("sat_pc", bus.pc, 32'h100);
    bus.branch_taken = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
